bus_mux_keeper: RTL and testbench
=================================

Name: bus_mux_keeper

Overview:
- Parametrised successor to the datapath bus multiplexer. It selects one of N_SRC WIDTH-bit sources onto the shared CPU bus from a one-hot "out" strobe vector.
- Adds an optional output register stage and a bus keeper that holds the last driven value when no source drives.
- Adds deterministic priority resolution plus sticky contention detection and counting, for debugging illegal control-unit states.
- Sits between register file / special registers / memory interface and every bus-loaded register.

Parameters:
- WIDTH, 32, data width of every source and of the bus.
- N_SRC, 24, number of sources (R0-R15, HI, LO, ZHigh, ZLow, PC, MDR, InPort, CSignExtended at default).
- REG_OUT, 1, 1 = bus_out/bus_valid/bus_src registered (1-cycle latency); 0 = combinational path.
- KEEP, 1, 1 = hold last driven value when no strobe is set; 0 = drive zero when idle.
- CNT_W, 8, width of the saturating contention counter.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  synchronous, active-low reset
- bus_in  input  N_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH]
- src_out  input  N_SRC  one-hot drive strobes (Rout equivalent); bit i = source i drives
- err_clr  input  1  clears contention flag, counter and capture
- bus_out  output  WIDTH  bus value
- bus_valid  output  1  a source drove bus_out this cycle (registered per REG_OUT)
- bus_src  output  $clog2(N_SRC)  index of winning source; 0 when idle
- contention  output  1  sticky: more than one strobe was ever set since the last clear or err_clr
- contention_cnt  output  CNT_W  number of contended cycles, saturating at all-ones
- conflict_vec  output  N_SRC  src_out captured on the first contended cycle after clear or err_clr

Behaviour:
- Reset (clear==0 at clock edge): bus_out=0, bus_valid=0, bus_src=0, contention=0, contention_cnt=0, conflict_vec=0, keeper register=0.
- Winner selection:
  - Winner = lowest set index of src_out.
  - any = |src_out.
  - multi = more than one bit set.
- Next bus value:
  - any=1: bus_in[winner].
  - any=0, KEEP=1: keeper value.
  - any=0, KEEP=0: 0.
- Keeper register loads bus_in[winner] on every edge with any=1 and holds otherwise, independent of REG_OUT.
- REG_OUT=1:
  - bus_out, bus_valid(=any), bus_src(=winner, or 0 when idle) update on the clock edge.
  - Latency 1 cycle from src_out/bus_in to bus_out.
- REG_OUT=0:
  - bus_out, bus_valid, bus_src are combinational from the current inputs.
  - Idle KEEP value comes from the keeper register.
  - Status outputs remain registered.
- Contention status updates on every edge with clear==1. When multi=1:
  - contention is set to 1.
  - contention_cnt increments if not all-ones.
  - conflict_vec loads src_out only if contention was 0 before this edge, so it holds the first offending pattern.
- err_clr=1 with multi=0: contention=0, contention_cnt=0, conflict_vec=0.
- err_clr=1 with multi=1 on the same edge: new event wins. contention=1, contention_cnt=1, conflict_vec=src_out.
- Contention never alters data selection; the lowest index still drives.
- Out-of-range strobes: none, since src_out has exactly N_SRC bits.
- Reset mid-operation: all state returns to reset values on that edge, and the keeper loses its held value.
- N_SRC=1 is legal: bus_src is 1 bit wide (clog2 clamped to a minimum of 1) and is always 0.

Decomposition:
- Package cpu_bus_pkg holds:
  - BUS_WIDTH=32 and BUS_N_SRC=24.
  - Source index constants SRC_R0..SRC_R15=0..15, SRC_HI=16, SRC_LO=17, SRC_ZHIGH=18, SRC_ZLOW=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_CSIGN=23.
  - A function for the src index width.
- One sub-module, onehot_prio_enc, parametrised by N. It takes a strobe vector and outputs idx (lowest set), any and multi, all combinational.
- The top level holds the data mux, the keeper, the output register and the status logic.

Test Plan:
- Reset: clear=0 for 2 cycles with random src_out -> all outputs 0; then clear=1, src_out=1<<20, PC source=0x0000_1234 -> next cycle bus_out=0x1234, bus_valid=1, bus_src=20.
- Walk each source i=0..23 driving value 0xA500_0000+i -> bus_out matches one cycle later (REG_OUT=1) or the same cycle (REG_OUT=0); contention stays 0.
- Keeper: R5 drives 0xDEAD_BEEF, then src_out=0 for 3 cycles -> KEEP=1: bus_out holds 0xDEADBEEF with bus_valid=0 and bus_src=0; KEEP=0: bus_out=0.
- Contention: src_out=(1<<3)|(1<<17) with R3=0x11, LO=0x22 -> bus_out=0x11, bus_src=3, contention=1, cnt=1, conflict_vec=0x020008; then (1<<1)|(1<<2) -> cnt=2, conflict_vec unchanged.
- Saturation and clear: CNT_W=2 with 5 contended cycles -> cnt=3; err_clr alone -> all status 0; err_clr together with a contended cycle -> cnt=1, conflict_vec=that cycle's src_out.
- Reset mid-stream: clear=0 while contention=1 and the keeper is holding -> all status 0 and bus_out=0 after the edge; idle cycles afterwards keep bus_out=0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus constants: default geometry, source indices and index-width helper.
package cpu_bus_pkg;
    localparam int BUS_WIDTH = 32;
    localparam int BUS_N_SRC = 24;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHIGH  = 18;
    localparam int SRC_ZLOW   = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_CSIGN  = 23;

    // A single-source bus still needs a 1-bit index port.
    function automatic int srcIdxW(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/onehot_prio_enc.sv
// Lowest-index-wins encoder for a drive-strobe vector, with any/multi flags.
module onehot_prio_enc
    import cpu_bus_pkg::*;
#(
    parameter int N = BUS_N_SRC,
    localparam int IW = srcIdxW(N)
) (
    input  logic [N-1:0]  strobe,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          multi
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (strobe[i]) idx = IW'(i);
        end
    end

    assign any = |strobe;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(strobe & (strobe - N'(1)));
endmodule

// File: rtl/bus_mux_keeper.sv
// Shared CPU bus multiplexer with bus keeper, optional output register and contention tracking.
module bus_mux_keeper
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH   = BUS_WIDTH,
    parameter int N_SRC   = BUS_N_SRC,
    parameter int REG_OUT = 1,
    parameter int KEEP    = 1,
    parameter int CNT_W   = 8,
    localparam int SW = srcIdxW(N_SRC)
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_SRC*WIDTH-1:0] bus_in,
    input  logic [N_SRC-1:0]       src_out,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_valid,
    output logic [SW-1:0]          bus_src,
    output logic                   contention,
    output logic [CNT_W-1:0]       contention_cnt,
    output logic [N_SRC-1:0]       conflict_vec
);
    logic [SW-1:0] winIdx;
    logic          any;
    logic          multi;

    onehot_prio_enc #(.N(N_SRC)) uEnc (
        .strobe (src_out),
        .idx    (winIdx),
        .any    (any),
        .multi  (multi)
    );

    logic [N_SRC-1:0][WIDTH-1:0] srcArr;
    logic [WIDTH-1:0]            selData;
    logic [WIDTH-1:0]            keepQ;
    logic [WIDTH-1:0]            nextBus;

    assign srcArr  = bus_in;
    assign selData = srcArr[winIdx];
    assign nextBus = any ? selData : ((KEEP != 0) ? keepQ : '0);

    // Keeper tracks the last driven value regardless of output registering.
    always_ff @(posedge clock) begin
        if (!clear)   keepQ <= '0;
        else if (any) keepQ <= selData;
    end

    generate
        if (REG_OUT != 0) begin : gRegOut
            always_ff @(posedge clock) begin
                if (!clear) begin
                    bus_out   <= '0;
                    bus_valid <= 1'b0;
                    bus_src   <= '0;
                end else begin
                    bus_out   <= nextBus;
                    bus_valid <= any;
                    bus_src   <= winIdx;
                end
            end
        end else begin : gCombOut
            assign bus_out   = nextBus;
            assign bus_valid = any;
            assign bus_src   = winIdx;
        end
    endgenerate

    // A contended cycle coinciding with err_clr restarts the record with that cycle.
    always_ff @(posedge clock) begin
        if (!clear) begin
            contention     <= 1'b0;
            contention_cnt <= '0;
            conflict_vec   <= '0;
        end else if (multi) begin
            contention <= 1'b1;
            if (err_clr) begin
                contention_cnt <= CNT_W'(1);
                conflict_vec   <= src_out;
            end else begin
                if (contention_cnt != '1) contention_cnt <= contention_cnt + CNT_W'(1);
                if (!contention)          conflict_vec   <= src_out;
            end
        end else if (err_clr) begin
            contention     <= 1'b0;
            contention_cnt <= '0;
            conflict_vec   <= '0;
        end
    end
endmodule

// File: tb/tb_bus_mux_keeper.sv
// Bench for bus_mux_keeper: a registered/keeping instance and a combinational/zeroing CNT_W=2 instance.
module tb_bus_mux_keeper;
    localparam int W = 32;
    localparam int N = 24;

    logic           clock;
    logic           clear;
    logic [N*W-1:0] busIn;
    logic [N-1:0]   srcOut;
    logic           errClr;

    logic [W-1:0] aBus, bBus;
    logic         aVal, bVal;
    logic [4:0]   aSrc, bSrc;
    logic         aCont, bCont;
    logic [7:0]   aCnt;
    logic [1:0]   bCnt;
    logic [N-1:0] aVec, bVec;

    bus_mux_keeper #(.WIDTH(W), .N_SRC(N), .REG_OUT(1), .KEEP(1), .CNT_W(8)) dutA (
        .clock(clock), .clear(clear), .bus_in(busIn), .src_out(srcOut), .err_clr(errClr),
        .bus_out(aBus), .bus_valid(aVal), .bus_src(aSrc), .contention(aCont),
        .contention_cnt(aCnt), .conflict_vec(aVec));

    bus_mux_keeper #(.WIDTH(W), .N_SRC(N), .REG_OUT(0), .KEEP(0), .CNT_W(2)) dutB (
        .clock(clock), .clear(clear), .bus_in(busIn), .src_out(srcOut), .err_clr(errClr),
        .bus_out(bBus), .bus_valid(bVal), .bus_src(bSrc), .contention(bCont),
        .contention_cnt(bCnt), .conflict_vec(bVec));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowIdx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [W-1:0] srcVal(input int i);
        return busIn[i*W +: W];
    endfunction

    // Model: keeper = last driven value; A's outputs are the rule applied one edge late.
    logic [W-1:0] mKeep, mOutA;
    logic         mValA;
    int           mSrcA;
    logic         mCont [2];
    int           mCnt  [2];
    logic [N-1:0] mVec  [2];
    int           capMax[2] = '{255, 3};
    bit           started = 1'b0;

    always @(posedge clock) begin
        started <= 1'b1;
        if (!clear) begin
            mKeep <= '0; mOutA <= '0; mValA <= 1'b0; mSrcA <= 0;
            for (int d = 0; d < 2; d++) begin
                mCont[d] <= 1'b0; mCnt[d] <= 0; mVec[d] <= '0;
            end
        end else begin
            mValA <= (srcOut != 0);
            mSrcA <= lowIdx(srcOut);
            if (srcOut != 0) begin
                mOutA <= srcVal(lowIdx(srcOut));
                mKeep <= srcVal(lowIdx(srcOut));
            end else begin
                mOutA <= mKeep;
            end
            for (int d = 0; d < 2; d++) begin
                if ($countones(srcOut) > 1) begin
                    mCont[d] <= 1'b1;
                    mCnt[d]  <= errClr ? 1 : ((mCnt[d] >= capMax[d]) ? capMax[d] : mCnt[d] + 1);
                    if (errClr || !mCont[d]) mVec[d] <= srcOut;
                end else if (errClr) begin
                    mCont[d] <= 1'b0; mCnt[d] <= 0; mVec[d] <= '0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("A.bus_out",   64'(aBus),  64'(mOutA));
            chk("A.bus_valid", 64'(aVal),  64'(mValA));
            chk("A.bus_src",   64'(aSrc),  64'(mSrcA));
            chk("B.bus_out",   64'(bBus),  (srcOut != 0) ? 64'(srcVal(lowIdx(srcOut))) : 64'd0);
            chk("B.bus_valid", 64'(bVal),  64'(srcOut != 0));
            chk("B.bus_src",   64'(bSrc),  64'(lowIdx(srcOut)));
            chk("A.cont",      64'(aCont), 64'(mCont[0]));
            chk("A.cnt",       64'(aCnt),  64'(mCnt[0]));
            chk("A.vec",       64'(aVec),  64'(mVec[0]));
            chk("B.cont",      64'(bCont), 64'(mCont[1]));
            chk("B.cnt",       64'(bCnt),  64'(mCnt[1]));
            chk("B.vec",       64'(bVec),  64'(mVec[1]));
        end
    end

    task automatic setSrc(input int i, input logic [W-1:0] v);
        busIn[i*W +: W] = v;
    endtask

    // Apply a vector, then return 2 time units after the edge that sampled it.
    task automatic cyc(input logic [N-1:0] s, input logic e, input logic c);
        srcOut = s; errClr = e; clear = c;
        @(posedge clock);
        #2;
    endtask

    task automatic chkStatus(input string tag, input int cnt, input logic [N-1:0] vec);
        chk({tag, ".A.cont"}, 64'(aCont), 64'(cnt != 0));
        chk({tag, ".A.cnt"},  64'(aCnt),  64'(cnt));
        chk({tag, ".A.vec"},  64'(aVec),  64'(vec));
    endtask

    initial begin
        clear = 1'b0; errClr = 1'b0; srcOut = '0;
        for (int i = 0; i < N; i++) setSrc(i, 32'h0100_0000 * i + 32'h55);

        for (int k = 0; k < 2; k++) begin
            cyc(N'($urandom), 1'b0, 1'b0);
            chk("rst.bus_out", 64'(aBus), 64'd0);
            chk("rst.bus_valid", 64'(aVal), 64'd0);
            chk("rst.bus_src", 64'(aSrc), 64'd0);
            chkStatus("rst", 0, '0);
            chk("rst.B.cnt", 64'(bCnt), 64'd0);
        end

        setSrc(20, 32'h0000_1234);
        cyc(N'(1) << 20, 1'b0, 1'b1);
        chk("pc.bus_out", 64'(aBus), 64'h1234);
        chk("pc.bus_valid", 64'(aVal), 64'd1);
        chk("pc.bus_src", 64'(aSrc), 64'd20);

        for (int i = 0; i < N; i++) begin
            setSrc(i, 32'hA500_0000 + 32'(i));
            cyc(N'(1) << i, 1'b0, 1'b1);
            chk("walk.A.bus_out", 64'(aBus), 64'(32'hA500_0000 + 32'(i)));
            chk("walk.B.bus_out", 64'(bBus), 64'(32'hA500_0000 + 32'(i)));
            chk("walk.A.cont", 64'(aCont), 64'd0);
        end

        setSrc(5, 32'hDEAD_BEEF);
        cyc(N'(1) << 5, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc('0, 1'b0, 1'b1);
            chk("keep.A.bus_out", 64'(aBus), 64'hDEAD_BEEF);
            chk("keep.A.bus_valid", 64'(aVal), 64'd0);
            chk("keep.A.bus_src", 64'(aSrc), 64'd0);
            chk("keep.B.bus_out", 64'(bBus), 64'd0);
        end

        setSrc(3, 32'h11); setSrc(17, 32'h22);
        cyc((N'(1) << 3) | (N'(1) << 17), 1'b0, 1'b1);
        chk("cont.bus_out", 64'(aBus), 64'h11);
        chk("cont.bus_src", 64'(aSrc), 64'd3);
        chkStatus("cont1", 1, 24'h020008);
        chk("cont1.B.vec", 64'(bVec), 64'h020008);
        cyc((N'(1) << 1) | (N'(1) << 2), 1'b0, 1'b1);
        chkStatus("cont2", 2, 24'h020008);
        chk("cont2.B.cnt", 64'(bCnt), 64'd2);

        for (int k = 0; k < 3; k++) cyc(24'h000C00, 1'b0, 1'b1);
        chk("sat.B.cnt", 64'(bCnt), 64'd3);
        chk("sat.A.cnt", 64'(aCnt), 64'd5);
        cyc(24'h000C00, 1'b0, 1'b1);
        chk("sat2.B.cnt", 64'(bCnt), 64'd3);

        cyc('0, 1'b1, 1'b1);
        chkStatus("errclr", 0, '0);
        chk("errclr.B.cont", 64'(bCont), 64'd0);
        chk("errclr.B.cnt", 64'(bCnt), 64'd0);

        cyc((N'(1) << 4) | (N'(1) << 9), 1'b1, 1'b1);
        chkStatus("errnew", 1, 24'h000210);
        chk("errnew.B.vec", 64'(bVec), 64'h000210);

        cyc(24'h000030, 1'b0, 1'b1);
        setSrc(7, 32'hCAFE_0007);
        cyc(N'(1) << 7, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        chk("hold.A.bus_out", 64'(aBus), 64'hCAFE_0007);
        chk("hold.A.cont", 64'(aCont), 64'd1);
        cyc('0, 1'b0, 1'b0);
        chk("midrst.A.bus_out", 64'(aBus), 64'd0);
        chkStatus("midrst", 0, '0);
        for (int k = 0; k < 2; k++) begin
            cyc('0, 1'b0, 1'b1);
            chk("postrst.A.bus_out", 64'(aBus), 64'd0);
            chk("postrst.A.bus_valid", 64'(aVal), 64'd0);
        end

        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] s;
            int r;
            r = $urandom_range(0, 3);
            s = '0;
            if (r == 1 || r == 2) s[$urandom_range(0, N - 1)] = 1'b1;
            if (r == 3) begin
                s[$urandom_range(0, N - 1)] = 1'b1;
                s[$urandom_range(0, N - 1)] = 1'b1;
            end
            setSrc($urandom_range(0, N - 1), 32'($urandom));
            cyc(s, ($urandom_range(0, 7) == 0), 1'b1);
        end

        cyc('0, 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
